// File: rtl/pacman_soc_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Round-robin with bounded hold; read data returns one clock after issue.
module pacman_soc_onchip_mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_MAX);

  logic            w_req0;
  logic            w_req1;
  logic            w_keep;
  logic            w_grant;
  logic            w_accept;
  logic            w_sel_write;
  logic            r_last;
  logic [CntW-1:0] r_hold_cnt;
  logic            r_rd_vld;
  logic            r_rd_own;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // A zero count only exists straight after reset: there is no run to protect,
  // so a contested cycle goes to the port that was not last (port 0).
  assign w_keep = (r_hold_cnt != '0) && (r_hold_cnt < HoldMax);

  always_comb begin
    w_grant = 1'b0;
    if (w_req0 && w_req1) begin
      w_grant = w_keep ? r_last : ~r_last;
    end else if (w_req1) begin
      w_grant = 1'b1;
    end
  end

  assign m0_waitrequest = reset | ~(~w_grant & w_req0);
  assign m1_waitrequest = reset | ~(w_grant & w_req1);
  assign w_accept       = ~reset & (w_grant ? w_req1 : w_req0);
  assign w_sel_write    = w_grant ? m1_write : m0_write;

  assign mem_address    = w_grant ? m1_address    : m0_address;
  assign mem_byteenable = w_grant ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_grant ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_accept;
  assign mem_write      = w_accept & w_sel_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_own   <= 1'b0;
    end else begin
      // Read+write together counts as a write, so it never produces a response.
      r_rd_vld <= w_accept & ~w_sel_write;
      r_rd_own <= w_grant;
      if (w_accept) begin
        r_last <= w_grant;
        if (w_grant != r_last) begin
          r_hold_cnt <= CntW'(1);
        end else if (r_hold_cnt < HoldMax) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  // A read issued just before reset must not surface while reset is high.
  assign m0_readdatavalid = ~reset & r_rd_vld & ~r_rd_own;
  assign m1_readdatavalid = ~reset & r_rd_vld & r_rd_own;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_pacman_soc_onchip_mem_arbiter.sv
// Bench: two arbiters (HOLD_MAX 4 and 1) on shared stimulus, each with its own RAM,
// checked against a transaction-level model of grants, shadow memory and read returns.
module tb_pacman_soc_onchip_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] a0, a1;
  logic          r0, w0, r1, w1;
  logic [BW-1:0] be0, be1;
  logic [DW-1:0] d0, d1;

  logic          a_wt0, a_wt1, a_rv0, a_rv1, a_cs, a_mw;
  logic [DW-1:0] a_rd0, a_rd1, a_mwd, a_mrd;
  logic [AW-1:0] a_ma;
  logic [BW-1:0] a_mbe;
  logic          b_wt0, b_wt1, b_rv0, b_rv1, b_cs, b_mw;
  logic [DW-1:0] b_rd0, b_rd1, b_mwd, b_mrd;
  logic [AW-1:0] b_ma;
  logic [BW-1:0] b_mbe;

  pacman_soc_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(4)) u_dut_a (
    .clk(clk), .reset(rst),
    .m0_address(a0), .m0_read(r0), .m0_write(w0), .m0_byteenable(be0), .m0_writedata(d0),
    .m0_waitrequest(a_wt0), .m0_readdata(a_rd0), .m0_readdatavalid(a_rv0),
    .m1_address(a1), .m1_read(r1), .m1_write(w1), .m1_byteenable(be1), .m1_writedata(d1),
    .m1_waitrequest(a_wt1), .m1_readdata(a_rd1), .m1_readdatavalid(a_rv1),
    .mem_address(a_ma), .mem_chipselect(a_cs), .mem_write(a_mw), .mem_byteenable(a_mbe),
    .mem_writedata(a_mwd), .mem_readdata(a_mrd)
  );

  pacman_soc_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(1)) u_dut_b (
    .clk(clk), .reset(rst),
    .m0_address(a0), .m0_read(r0), .m0_write(w0), .m0_byteenable(be0), .m0_writedata(d0),
    .m0_waitrequest(b_wt0), .m0_readdata(b_rd0), .m0_readdatavalid(b_rv0),
    .m1_address(a1), .m1_read(r1), .m1_write(w1), .m1_byteenable(be1), .m1_writedata(d1),
    .m1_waitrequest(b_wt1), .m1_readdata(b_rd1), .m1_readdatavalid(b_rv1),
    .mem_address(b_ma), .mem_chipselect(b_cs), .mem_write(b_mw), .mem_byteenable(b_mbe),
    .mem_writedata(b_mwd), .mem_readdata(b_mrd)
  );

  // RAM models: registered address, unregistered q.
  logic [DW-1:0] ram_a [1024];
  logic [DW-1:0] ram_b [1024];
  logic [AW-1:0] ra_q, rb_q;
  initial for (int i = 0; i < 1024; i++) begin ram_a[i] = '0; ram_b[i] = '0; end
  always @(posedge clk) if (a_cs) begin
    if (a_mw) for (int b = 0; b < BW; b++) if (a_mbe[b]) ram_a[a_ma][8*b+:8] <= a_mwd[8*b+:8];
    ra_q <= a_ma;
  end
  always @(posedge clk) if (b_cs) begin
    if (b_mw) for (int b = 0; b < BW; b++) if (b_mbe[b]) ram_b[b_ma][8*b+:8] <= b_mwd[8*b+:8];
    rb_q <= b_ma;
  end
  assign a_mrd = ram_a[ra_q];
  assign b_mrd = ram_b[rb_q];

  logic [1:0]         wt0, wt1, rv0, rv1, cs, mw;
  logic [1:0][DW-1:0] rd0, rd1, mwd;
  logic [1:0][AW-1:0] ma;
  logic [1:0][BW-1:0] mbe;
  assign wt0 = {b_wt0, a_wt0};
  assign wt1 = {b_wt1, a_wt1};
  assign rv0 = {b_rv0, a_rv0};
  assign rv1 = {b_rv1, a_rv1};
  assign cs  = {b_cs, a_cs};
  assign mw  = {b_mw, a_mw};
  assign rd0 = {b_rd0, a_rd0};
  assign rd1 = {b_rd1, a_rd1};
  assign mwd = {b_mwd, a_mwd};
  assign ma  = {b_ma, a_ma};
  assign mbe = {b_mbe, a_mbe};

  // Reference model: last winner, length of its current run, pending read, shadow memory.
  int            hmax [2] = '{4, 1};
  logic          m_last [2];
  int            m_run [2];
  logic          m_pv [2];
  logic          m_pp [2];
  logic [DW-1:0] m_pd [2];
  logic [DW-1:0] sh [2][1024];
  int            checks = 0;
  int            errors = 0;

  function automatic int exp_grant(int d);
    bit q0, q1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    if (!q0 && !q1) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (m_run[d] > 0 && m_run[d] < hmax[d]) return m_last[d] ? 1 : 0;
    return m_last[d] ? 0 : 1;
  endfunction

  task automatic idle();
    r0 = 0; w0 = 0; r1 = 0; w1 = 0; a0 = '0; a1 = '0;
    be0 = '1; be1 = '1; d0 = '0; d1 = '0;
  endtask

  // Advance the model with the inputs currently applied, then move to the next cycle.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int            g;
      logic [AW-1:0] a;
      logic          rd, wr;
      logic [BW-1:0] be;
      logic [DW-1:0] dat;
      g = exp_grant(d);
      a = (g == 1) ? a1 : a0;
      rd = (g == 1) ? r1 : r0;
      wr = (g == 1) ? w1 : w0;
      be = (g == 1) ? be1 : be0;
      dat = (g == 1) ? d1 : d0;
      if (rst) begin
        m_last[d] = 1'b1; m_run[d] = 0; m_pv[d] = 1'b0;
      end else if (g < 0) begin
        m_pv[d] = 1'b0;
      end else begin
        m_run[d] = ((g == 1) == m_last[d]) ? m_run[d] + 1 : 1;
        m_last[d] = (g == 1);
        m_pv[d] = rd & ~wr;
        m_pp[d] = (g == 1);
        m_pd[d] = sh[d][a];
        if (wr) for (int b = 0; b < BW; b++) if (be[b]) sh[d][a][8*b+:8] = dat[8*b+:8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); r0 = 1; r1 = 1; a0 = 3; a1 = 4;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], wt1[d], cs[d], mw[d], rv0[d], rv1[d]} !== 6'b110000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b want 110000", d,
                 {wt0[d], wt1[d], cs[d], mw[d], rv0[d], rv1[d]});
      end
    end
    tick(); tick();
    rst = 0; idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], wt1[d], cs[d], rv0[d], rv1[d]} !== 5'b11000) begin
        errors++;
        $display("FAIL idle_outputs dut%0d: got %b want 11000", d,
                 {wt0[d], wt1[d], cs[d], rv0[d], rv1[d]});
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    idle(); w0 = 1; a0 = 5; be0 = 4'hF; d0 = 32'h12345678;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], cs[d], mw[d], ma[d], mbe[d], mwd[d]} !== {3'b011, 10'd5, 4'hF, 32'h12345678})
      begin
        errors++;
        $display("FAIL write_issue dut%0d: got wt=%b cs=%b we=%b a=%0d be=%h d=%h", d, wt0[d],
                 cs[d], mw[d], ma[d], mbe[d], mwd[d]);
      end
    end
    tick();
    idle(); r0 = 1; a0 = 5;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], cs[d], mw[d]} !== 3'b010) begin
        errors++;
        $display("FAIL read_issue dut%0d: got %b want 010", d, {wt0[d], cs[d], mw[d]});
      end
    end
    tick();
    idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv0[d], rv1[d]} !== 2'b10 || rd0[d] !== 32'h12345678) begin
        errors++;
        $display("FAIL read_return dut%0d: got vld=%b data=%h want 10 12345678", d,
                 {rv0[d], rv1[d]}, rd0[d]);
      end
    end
    tick();
  endtask

  task automatic test_byte_write();
    idle(); w1 = 1; a1 = 5; be1 = 4'b0010; d1 = 32'h0000AB00;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt1[d], cs[d], mw[d]} !== 3'b011) begin
        errors++;
        $display("FAIL byte_write_issue dut%0d: got %b want 011", d, {wt1[d], cs[d], mw[d]});
      end
    end
    tick();
    idle(); r1 = 1; a1 = 5;
    tick();
    idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv0[d], rv1[d]} !== 2'b01 || rd1[d] !== 32'h1234AB78) begin
        errors++;
        $display("FAIL byte_write_return dut%0d: got vld=%b data=%h want 01 1234ab78", d,
                 {rv0[d], rv1[d]}, rd1[d]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      {r0, w0} = 2'($urandom_range(0, 3));
      {r1, w1} = 2'($urandom_range(0, 3));
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      be0 = BW'($urandom); be1 = BW'($urandom); d0 = $urandom; d1 = $urandom;
      #2;
      for (int d = 0; d < 2; d++) begin
        int   g;
        logic e_w0, e_w1, e_cs, e_mw, e_rv0, e_rv1;
        g = exp_grant(d);
        e_w0 = rst || g != 0;
        e_w1 = rst || g != 1;
        e_cs = !rst && g >= 0;
        e_mw = e_cs && ((g == 1) ? w1 : w0);
        e_rv0 = !rst && m_pv[d] && !m_pp[d];
        e_rv1 = !rst && m_pv[d] && m_pp[d];
        checks++;
        if ({wt0[d], wt1[d], cs[d], mw[d], rv0[d], rv1[d]} !==
            {e_w0, e_w1, e_cs, e_mw, e_rv0, e_rv1}) begin
          errors++;
          $display("FAIL rand_ctrl dut%0d cyc%0d: got %b want %b", d, i,
                   {wt0[d], wt1[d], cs[d], mw[d], rv0[d], rv1[d]},
                   {e_w0, e_w1, e_cs, e_mw, e_rv0, e_rv1});
        end
        if (e_cs) begin
          checks++;
          if (ma[d] !== ((g == 1) ? a1 : a0)) begin
            errors++;
            $display("FAIL rand_addr dut%0d cyc%0d: got %0d want %0d", d, i, ma[d],
                     (g == 1) ? a1 : a0);
          end
        end
        if (e_mw) begin
          checks++;
          if ({mbe[d], mwd[d]} !== ((g == 1) ? {be1, d1} : {be0, d0})) begin
            errors++;
            $display("FAIL rand_wdata dut%0d cyc%0d: got %h/%h", d, i, mbe[d], mwd[d]);
          end
        end
        if (e_rv0 || e_rv1) begin
          checks++;
          if ((e_rv1 ? rd1[d] : rd0[d]) !== m_pd[d]) begin
            errors++;
            $display("FAIL rand_rdata dut%0d cyc%0d: got %h want %h", d, i,
                     e_rv1 ? rd1[d] : rd0[d], m_pd[d]);
          end
        end
      end
      tick();
    end
    rst = 0; idle(); tick();
  endtask

  task automatic test_round_robin();
    // Leave port 1 as last winner on a short run so only the reset gives port 0 the first turn.
    idle(); w0 = 1; a0 = 20; d0 = $urandom; tick();
    idle(); w1 = 1; a1 = 21; d1 = $urandom; tick();
    rst = 1; idle(); tick();
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      r0 = 1; r1 = 1; a0 = AW'($urandom_range(0, 31)); a1 = AW'($urandom_range(0, 31));
      #2;
      for (int d = 0; d < 2; d++) begin
        int eg, pg;
        eg = (d == 0) ? (i / 4) % 2 : i % 2;
        checks++;
        if ({wt0[d], wt1[d]} !== ((eg == 1) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant dut%0d cyc%0d: got wait %b want port %0d", d, i,
                   {wt0[d], wt1[d]}, eg);
        end
        if (i > 0) begin
          pg = (d == 0) ? ((i - 1) / 4) % 2 : (i - 1) % 2;
          checks++;
          if ({rv0[d], rv1[d]} !== ((pg == 1) ? 2'b01 : 2'b10) ||
              ((pg == 1) ? rd1[d] : rd0[d]) !== m_pd[d]) begin
            errors++;
            $display("FAIL rr_return dut%0d cyc%0d: got vld=%b data=%h want port %0d data %h",
                     d, i, {rv0[d], rv1[d]}, (pg == 1) ? rd1[d] : rd0[d], pg, m_pd[d]);
          end
        end
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_single_stream();
    int acc [2];
    acc[0] = 0; acc[1] = 0;
    for (int i = 0; i < 10; i++) begin
      idle(); r1 = 1; a1 = AW'(i);
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (wt1[d] !== 1'b0 || cs[d] !== 1'b1) begin
          errors++;
          $display("FAIL stream_accept dut%0d cyc%0d: got wait=%b cs=%b want 0 1", d, i,
                   wt1[d], cs[d]);
        end
        if (wt1[d] === 1'b0 && cs[d] === 1'b1) acc[d]++;
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (acc[d] != 10) begin
        errors++;
        $display("FAIL stream_count dut%0d: got %0d want 10", d, acc[d]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_reset_drop();
    idle(); r0 = 1; a0 = 5;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wt0[d] !== 1'b0) begin
        errors++;
        $display("FAIL rd_before_reset dut%0d: got wait %b want 0", d, wt0[d]);
      end
    end
    tick();
    rst = 1; idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv0[d], rv1[d]} !== 2'b00) begin
        errors++;
        $display("FAIL rd_killed_by_reset dut%0d: got vld %b want 00", d, {rv0[d], rv1[d]});
      end
    end
    tick();
    rst = 0; r0 = 1; r1 = 1; a0 = 1; a1 = 2;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], wt1[d], rv0[d], rv1[d]} !== 4'b0100) begin
        errors++;
        $display("FAIL post_reset_grant dut%0d: got %b want 0100", d,
                 {wt0[d], wt1[d], rv0[d], rv1[d]});
      end
    end
    tick();
    idle(); tick();
  endtask

  task automatic test_read_write_both();
    logic [DW-1:0] dat;
    dat = $urandom;
    idle(); r0 = 1; w0 = 1; a0 = 9; d0 = dat;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wt0[d], cs[d], mw[d]} !== 3'b011) begin
        errors++;
        $display("FAIL rw_as_write dut%0d: got %b want 011", d, {wt0[d], cs[d], mw[d]});
      end
    end
    tick();
    idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv0[d], rv1[d]} !== 2'b00) begin
        errors++;
        $display("FAIL rw_no_response dut%0d: got vld %b want 00", d, {rv0[d], rv1[d]});
      end
    end
    r0 = 1; a0 = 9;
    tick();
    idle();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rv0[d] !== 1'b1 || rd0[d] !== dat) begin
        errors++;
        $display("FAIL rw_readback dut%0d: got vld=%b data=%h want 1 %h", d, rv0[d], rd0[d],
                 dat);
      end
    end
    tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) sh[d][i] = '0;
      m_last[d] = 1'b1; m_run[d] = 0; m_pv[d] = 1'b0; m_pp[d] = 1'b0; m_pd[d] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_write();
    test_random();
    test_round_robin();
    test_single_stream();
    test_reset_drop();
    test_read_write_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
